// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller and the datapath
// operand muxes that consume its forwarding selects.
//   FWD_RF / FWD_W / FWD_M : execute-stage operand select encodings
//   sb_entry_t             : one scoreboard entry (execute, memory, writeback)
//   is_producer()          : entry will write a real (non-zero) register
// Addresses are stored at SB_ADDR_W bits; RADDR_W of the controller must not
// exceed SB_ADDR_W (narrower addresses are zero-extended on entry).
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam int SB_ADDR_W = 8;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] rs;
      logic [SB_ADDR_W-1:0] rt;
      logic                 uses_rs;
      logic                 uses_rt;
      logic [SB_ADDR_W-1:0] dst;
      logic                 regwrite;
      logic                 load;
   } sb_entry_t;

   // All-zero entry: valid, regwrite and load low, so it never produces.
   localparam sb_entry_t SB_BUBBLE = '0;

   // Register 0 is hardwired, so a write to it is never a dependency source.
   function automatic logic is_producer(input sb_entry_t ent);
      return ent.valid & ent.regwrite & (ent.dst != {SB_ADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Compares one source register address against one scoreboard entry.
//   addr  in  source register address (zero-extended to SB_ADDR_W)
//   uses  in  the instruction really reads this source
//   ent   in  scoreboard entry being checked
//   match out entry produces the register this source reads
// -----------------------------------------------------------------------------
module hazard_cmp
   import hazard_ctrl_pkg::*;
(
   input  logic [SB_ADDR_W-1:0] addr,
   input  logic                 uses,
   input  sb_entry_t            ent,
   output logic                 match
);

   // Source-side fields of the entry are not relevant to a producer check.
   logic unused_ent_s;
   assign unused_ent_s = ^{ent.rs, ent.rt, ent.uses_rs, ent.uses_rt, ent.load};

   assign match = uses & is_producer(ent) & (addr == ent.dst);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard detection / forwarding control for a 5-stage in-order pipeline.
// Tracks the instructions in execute, memory and writeback in a small
// scoreboard and derives stalls, flushes and forwarding selects from it.
//   clk, reset                 clock, asynchronous active-low reset
//   d_valid ... d_load         decode-stage instruction description
//   m_pc_src                   taken branch resolved in memory stage
//   stall_f, stall_d           hold fetch PC / decode register
//   flush_d, flush_e, flush_m  bubble into decode / execute / memory
//   fwd_a_e, fwd_b_e           execute operand selects (FWD_RF/FWD_W/FWD_M)
//   stall_cnt, flush_cnt       saturating event counters
// All hazard outputs are combinational (zero latency) and forced low while
// reset is asserted.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int RADDR_W    = 5,
   parameter int FWD_EN     = 1,
   parameter int REG_BYPASS = 1,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               d_valid,
   input  logic [RADDR_W-1:0] d_rs,
   input  logic [RADDR_W-1:0] d_rt,
   input  logic               d_uses_rs,
   input  logic               d_uses_rt,
   input  logic [RADDR_W-1:0] d_dst,
   input  logic               d_regwrite,
   input  logic               d_load,
   input  logic               m_pc_src,
   output logic               stall_f,
   output logic               stall_d,
   output logic               flush_d,
   output logic               flush_e,
   output logic               flush_m,
   output logic [1:0]         fwd_a_e,
   output logic [1:0]         fwd_b_e,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   sb_entry_t            sb_e_r, sb_m_r, sb_w_r;
   sb_entry_t            dec_s;
   sb_entry_t [2:0]      ent_s;          // 0 = execute, 1 = memory, 2 = writeback
   logic [SB_ADDR_W-1:0] d_rs_s, d_rt_s;
   logic [2:0]           m_drs_s, m_drt_s; // decode sources vs E/M/W
   logic [1:0]           m_ers_s, m_ert_s; // execute sources vs M/W
   logic                 hz_s;
   logic                 stall_s, flush_d_s, flush_e_s, flush_m_s;
   logic [1:0]           fwd_a_s, fwd_b_s;
   logic [CNT_W-1:0]     stall_cnt_r, flush_cnt_r;

   assign d_rs_s = SB_ADDR_W'(d_rs);
   assign d_rt_s = SB_ADDR_W'(d_rt);

   // Scoreboard entry describing the instruction currently in decode.
   always_comb begin
      dec_s          = SB_BUBBLE;
      dec_s.valid    = 1'b1;
      dec_s.rs       = d_rs_s;
      dec_s.rt       = d_rt_s;
      dec_s.uses_rs  = d_uses_rs;
      dec_s.uses_rt  = d_uses_rt;
      dec_s.dst      = SB_ADDR_W'(d_dst);
      dec_s.regwrite = d_regwrite;
      dec_s.load     = d_load;
   end

   assign ent_s[0] = sb_e_r;
   assign ent_s[1] = sb_m_r;
   assign ent_s[2] = sb_w_r;

   genvar ge;
   // Decode sources checked against every downstream entry.
   for (ge = 0; ge < 3; ge++) begin : g_dec
      hazard_cmp u_cmp_rs (
         .addr  (d_rs_s),
         .uses  (d_uses_rs),
         .ent   (ent_s[ge]),
         .match (m_drs_s[ge])
      );
      hazard_cmp u_cmp_rt (
         .addr  (d_rt_s),
         .uses  (d_uses_rt),
         .ent   (ent_s[ge]),
         .match (m_drt_s[ge])
      );
   end

   // Execute sources checked against the two older entries for forwarding.
   for (ge = 1; ge < 3; ge++) begin : g_exe
      hazard_cmp u_cmp_rs (
         .addr  (sb_e_r.rs),
         .uses  (sb_e_r.uses_rs),
         .ent   (ent_s[ge]),
         .match (m_ers_s[ge-1])
      );
      hazard_cmp u_cmp_rt (
         .addr  (sb_e_r.rt),
         .uses  (sb_e_r.uses_rt),
         .ent   (ent_s[ge]),
         .match (m_ert_s[ge-1])
      );
   end

   // Data hazard that needs decode held: only a load in execute when
   // forwarding, otherwise any in-flight producer the register file cannot
   // yet supply (writeback is covered by a same-cycle bypassing regfile).
   always_comb begin
      hz_s = 1'b0;
      if (FWD_EN != 0) begin
         hz_s = d_valid & sb_e_r.load & (m_drs_s[0] | m_drt_s[0]);
      end else begin
         hz_s = d_valid & ((|m_drs_s[1:0]) | (|m_drt_s[1:0]) |
                           ((REG_BYPASS == 0) & (m_drs_s[2] | m_drt_s[2])));
      end
   end

   // Stall / flush / forward decode; a taken branch squashes the stalled
   // instruction anyway, so it overrides the stall.
   always_comb begin
      stall_s   = 1'b0;
      flush_d_s = 1'b0;
      flush_e_s = 1'b0;
      flush_m_s = 1'b0;
      fwd_a_s   = FWD_RF;
      fwd_b_s   = FWD_RF;
      if (reset) begin
         flush_d_s = m_pc_src;
         flush_m_s = m_pc_src;
         flush_e_s = m_pc_src | hz_s;
         stall_s   = hz_s & ~m_pc_src;
         if (FWD_EN != 0) begin
            // Memory stage holds the younger value, so it wins over writeback.
            if (m_ers_s[0]) begin
               fwd_a_s = FWD_M;
            end else if (m_ers_s[1]) begin
               fwd_a_s = FWD_W;
            end else begin
               fwd_a_s = FWD_RF;
            end
            if (m_ert_s[0]) begin
               fwd_b_s = FWD_M;
            end else if (m_ert_s[1]) begin
               fwd_b_s = FWD_W;
            end else begin
               fwd_b_s = FWD_RF;
            end
         end else begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
         end
      end else begin
         stall_s   = 1'b0;
         flush_d_s = 1'b0;
      end
   end

   // Scoreboard shift: decode -> execute -> memory -> writeback.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_e_r <= SB_BUBBLE;
         sb_m_r <= SB_BUBBLE;
         sb_w_r <= SB_BUBBLE;
      end else begin
         sb_w_r <= sb_m_r;
         sb_m_r <= flush_m_s ? SB_BUBBLE : sb_e_r;
         sb_e_r <= (flush_e_s || !d_valid) ? SB_BUBBLE : dec_s;
      end
   end

   // Saturating stall / flush event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if (flush_m_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign stall_f   = stall_s;
   assign stall_d   = stall_s;
   assign flush_d   = flush_d_s;
   assign flush_e   = flush_e_s;
   assign flush_m   = flush_m_s;
   assign fwd_a_e   = fwd_a_s;
   assign fwd_b_e   = fwd_b_s;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Three hazard_ctrl instances share one stimulus stream:
//   dut 0 : forwarding,  bypassing regfile, 16-bit counters
//   dut 1 : stall-only,  bypassing regfile, 16-bit counters
//   dut 2 : stall-only,  non-bypassing regfile, 2-bit counters
// A reference model tracks the in-flight instructions of each configuration
// as plain records; expected outputs go into a queue and a negedge monitor
// compares them against the DUTs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, d_valid, d_uses_rs, d_uses_rt, d_regwrite, d_load, m_pc_src;
   logic [4:0] d_rs, d_rt, d_dst;

   logic [2:0]       stall_f, stall_d, flush_d, flush_e, flush_m;
   logic [2:0][1:0]  fwd_a, fwd_b;
   logic [15:0]      scnt0, fcnt0, scnt1, fcnt1;
   logic [1:0]       scnt2, fcnt2;

   hazard_ctrl #(.RADDR_W(5), .FWD_EN(1), .REG_BYPASS(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_dst(d_dst),
      .d_regwrite(d_regwrite), .d_load(d_load), .m_pc_src(m_pc_src),
      .stall_f(stall_f[0]), .stall_d(stall_d[0]), .flush_d(flush_d[0]),
      .flush_e(flush_e[0]), .flush_m(flush_m[0]), .fwd_a_e(fwd_a[0]),
      .fwd_b_e(fwd_b[0]), .stall_cnt(scnt0), .flush_cnt(fcnt0));

   hazard_ctrl #(.RADDR_W(5), .FWD_EN(0), .REG_BYPASS(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_dst(d_dst),
      .d_regwrite(d_regwrite), .d_load(d_load), .m_pc_src(m_pc_src),
      .stall_f(stall_f[1]), .stall_d(stall_d[1]), .flush_d(flush_d[1]),
      .flush_e(flush_e[1]), .flush_m(flush_m[1]), .fwd_a_e(fwd_a[1]),
      .fwd_b_e(fwd_b[1]), .stall_cnt(scnt1), .flush_cnt(fcnt1));

   hazard_ctrl #(.RADDR_W(5), .FWD_EN(0), .REG_BYPASS(0), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_dst(d_dst),
      .d_regwrite(d_regwrite), .d_load(d_load), .m_pc_src(m_pc_src),
      .stall_f(stall_f[2]), .stall_d(stall_d[2]), .flush_d(flush_d[2]),
      .flush_e(flush_e[2]), .flush_m(flush_m[2]), .fwd_a_e(fwd_a[2]),
      .fwd_b_e(fwd_b[2]), .stall_cnt(scnt2), .flush_cnt(fcnt2));

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] dst;
      logic       rw, ld;
   } ins_t;

   typedef struct packed {
      logic [1:0]  k;
      logic        sf, sd, fd, fe, fm;
      logic [1:0]  fa, fb;
      logic [15:0] sc, fc;
   } exp_t;

   ins_t pe [3];
   ins_t pm [3];
   ins_t pw [3];
   int   scnt_m [3];
   int   fcnt_m [3];
   int   cnt_max [3] = '{65535, 65535, 3};
   bit   cfg_fwd [3] = '{1'b1, 1'b0, 1'b0};
   bit   cfg_byp [3] = '{1'b1, 1'b1, 1'b0};
   exp_t exp_q [$];

   int n_cmp = 0;
   int n_fail = 0;

   function automatic bit writes(input ins_t x, input logic [4:0] r);
      return x.v && x.rw && (x.dst != 5'd0) && (x.dst == r);
   endfunction

   function automatic bit reads(input ins_t d, input ins_t x);
      return (d.urs && writes(x, d.rs)) || (d.urt && writes(x, d.rt));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic u, input logic [4:0] a,
                                          input ins_t m, input ins_t w);
      if (!u) return 2'b00;
      if (writes(m, a)) return 2'b10;
      if (writes(w, a)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic ins_t dec_ins();
      ins_t d;
      d.v = 1'b1; d.rs = d_rs; d.rt = d_rt; d.urs = d_uses_rs; d.urt = d_uses_rt;
      d.dst = d_dst; d.rw = d_regwrite; d.ld = d_load;
      return d;
   endfunction

   function automatic exp_t predict(input int k);
      exp_t r;
      ins_t d;
      bit   hz;
      r = '0;
      r.k = 2'(k);
      if (reset !== 1'b1) return r;
      d = dec_ins();
      r.sc = 16'(scnt_m[k]);
      r.fc = 16'(fcnt_m[k]);
      if (cfg_fwd[k]) begin
         hz = d_valid && pe[k].ld && reads(d, pe[k]);
         r.fa = fwd_sel(pe[k].urs, pe[k].rs, pm[k], pw[k]);
         r.fb = fwd_sel(pe[k].urt, pe[k].rt, pm[k], pw[k]);
      end else begin
         hz = d_valid && (reads(d, pe[k]) || reads(d, pm[k]) ||
                          (!cfg_byp[k] && reads(d, pw[k])));
      end
      r.fd = m_pc_src;
      r.fm = m_pc_src;
      r.fe = hz || m_pc_src;
      r.sf = hz && !m_pc_src;
      r.sd = r.sf;
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         pe[k] = '0; pm[k] = '0; pw[k] = '0;
         scnt_m[k] = 0; fcnt_m[k] = 0;
      end
   endtask

   task automatic model_clock();
      exp_t r;
      ins_t bub;
      bub = '0;
      for (int k = 0; k < 3; k++) begin
         r = predict(k);
         if (reset !== 1'b1) begin
            pe[k] = bub; pm[k] = bub; pw[k] = bub;
            scnt_m[k] = 0; fcnt_m[k] = 0;
         end else begin
            if (r.sd && scnt_m[k] < cnt_max[k]) scnt_m[k]++;
            if (m_pc_src && fcnt_m[k] < cnt_max[k]) fcnt_m[k]++;
            pw[k] = pm[k];
            pm[k] = m_pc_src ? bub : pe[k];
            pe[k] = (r.fe || !d_valid) ? bub : dec_ins();
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int k, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d at t=%0t", nm, k, act, expv, $time);
      end
   endtask

   function automatic int act_sc(input int k);
      case (k)
         0:       return int'(scnt0);
         1:       return int'(scnt1);
         default: return int'(scnt2);
      endcase
   endfunction

   function automatic int act_fc(input int k);
      case (k)
         0:       return int'(fcnt0);
         1:       return int'(fcnt1);
         default: return int'(fcnt2);
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   k;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         k = int'(e.k);
         chk("stall_f",   k, int'(stall_f[k]), int'(e.sf));
         chk("stall_d",   k, int'(stall_d[k]), int'(e.sd));
         chk("flush_d",   k, int'(flush_d[k]), int'(e.fd));
         chk("flush_e",   k, int'(flush_e[k]), int'(e.fe));
         chk("flush_m",   k, int'(flush_m[k]), int'(e.fm));
         chk("fwd_a_e",   k, int'(fwd_a[k]),   int'(e.fa));
         chk("fwd_b_e",   k, int'(fwd_b[k]),   int'(e.fb));
         chk("stall_cnt", k, act_sc(k),        int'(e.sc));
         chk("flush_cnt", k, act_fc(k),        int'(e.fc));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input bit dv, input int rs, input int rt, input bit urs,
                         input bit urt, input int dst, input bit rw, input bit ld,
                         input bit pc);
      d_valid = dv; d_rs = 5'(rs); d_rt = 5'(rt); d_uses_rs = urs; d_uses_rt = urt;
      d_dst = 5'(dst); d_regwrite = rw; d_load = ld; m_pc_src = pc;
   endtask

   task automatic push_all();
      for (int k = 0; k < 3; k++) exp_q.push_back(predict(k));
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic cycle(input bit dv, input int rs, input int rt, input bit urs,
                        input bit urt, input int dst, input bit rw, input bit ld,
                        input bit pc);
      set_in(dv, rs, rt, urs, urt, dst, rw, ld, pc);
      push_all();
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      idle(2);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // add r3; sub uses r3 as rs; third reads r3 as rt
      cycle(1, 1, 2, 1, 1, 3, 1, 0, 0);
      cycle(1, 3, 4, 1, 1, 6, 1, 0, 0);
      chk("b2b_fwd_m", 0, int'(fwd_a[0]), 2);
      chk("b2b_nostall", 0, int'(stall_d[0]), 0);
      cycle(1, 7, 3, 1, 1, 8, 1, 0, 0);
      chk("gap_fwd_w", 0, int'(fwd_b[0]), 1);
      idle(3);

      // lw r2; add r4,r2,r5 held through one stall
      cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
      cycle(1, 2, 5, 1, 1, 4, 1, 0, 0);
      cycle(1, 2, 5, 1, 1, 4, 1, 0, 0);
      chk("ldu_fwd_w", 0, int'(fwd_a[0]), 1);
      chk("ldu_stall_cnt", 0, int'(scnt0), 1);
      idle(3);

      // load-use hazard coinciding with a taken branch
      cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
      set_in(1, 2, 5, 1, 1, 4, 1, 0, 1);
      push_all();
      #1;
      chk("br_stall_d", 0, int'(stall_d[0]), 0);
      chk("br_flush_m", 0, int'(flush_m[0]), 1);
      step();
      chk("br_flush_cnt", 0, int'(fcnt0), 1);
      idle(3);

      // stall-only dependent pair, twice: 2 stalls (bypass) / 3 stalls (none)
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
         for (int i = 0; i < 4; i++) cycle(1, 3, 0, 1, 0, 5, 1, 0, 0);
         idle(3);
         chk("so_byp_cnt", 1, int'(scnt1), 2 * (rep + 1));
         chk("so_nobyp_cnt", 2, int'(scnt2), 3);
      end

      // writer to r0 followed by reader of r0
      cycle(1, 0, 0, 0, 0, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 1, 7, 1, 0, 0);
      cycle(1, 0, 0, 1, 1, 7, 1, 0, 0);
      idle(3);
      chk("r0_stall0", 0, int'(scnt0), 0);
      chk("r0_stall1", 1, int'(scnt1), 4);

      // reset pulled low between edges while hazards are pending
      cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
      set_in(1, 2, 2, 1, 1, 4, 1, 0, 1);
      #2;
      reset = 1'b0;
      model_clear();
      push_all();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("rel_stall_cnt", 0, int'(scnt0), 0);
      chk("rel_flush_cnt", 2, int'(fcnt2), 0);
      push_all();
      step();

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         cycle(($urandom % 8) != 0, $urandom % 8, $urandom % 8, $urandom % 2,
               $urandom % 2, $urandom % 8, ($urandom % 4) != 0,
               ($urandom % 4) == 0, ($urandom % 12) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding mode, 0 = stall-only mode.
REQ-003 SHALL have parameter REG_BYPASS, default 1; 1 = register file returns same-cycle write data, 0 = it does not.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have ports:
 clk  in  1  sole clock, rising edge;
 reset  in  1  asynchronous, active-low reset;
 d_valid  in  1  decode stage holds a real instruction;
 d_rs, d_rt  in  RADDR_W  decode source registers;
 d_uses_rs, d_uses_rt  in  1  source actually read;
 d_dst  in  RADDR_W  decode destination (already RegDst-resolved);
 d_regwrite  in  1  instruction writes d_dst;
 d_load  in  1  instruction is a load (MemToReg);
 m_pc_src  in  1  taken branch resolved in memory stage;
 stall_f, stall_d  out  1  hold fetch PC / decode register;
 flush_d, flush_e, flush_m  out  1  bubble into decode / execute / memory register;
 fwd_a_e, fwd_b_e  out  2  execute operand select: 00 regfile, 10 ALUOutM, 01 ResultW;
 stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Function
REQ-006 SHALL keep a scoreboard of three entries: E {valid, rs, rt, uses_rs, uses_rt, dst, regwrite, load}, M {valid, dst, regwrite, load}, W {valid, dst, regwrite}.
REQ-007 Every clock SHALL shift: W <= M; M <= flush_m ? bubble : E; E <= (flush_e or !d_valid) ? bubble : decode inputs.
REQ-008 A bubble SHALL have valid=0, regwrite=0, load=0; only entries with valid=1, regwrite=1, dst!=0 SHALL count as producers.
REQ-009 Register 0 SHALL never cause a stall or forward.
REQ-010 FWD_EN=1: fwd_a_e=10 if E.uses_rs and M produces E.rs; else 01 if W produces E.rs; else 00; fwd_b_e identical using rt; M SHALL take priority over W.
REQ-011 FWD_EN=1: load-use hazard = d_valid and E is a producing load and (d_uses_rs and d_rs==E.dst or d_uses_rt and d_rt==E.dst); SHALL assert stall_f=stall_d=flush_e for that cycle (exactly one bubble).
REQ-012 FWD_EN=0: fwd outputs SHALL be 00; stall_f=stall_d=flush_e SHALL assert while any of E, M (and W when REG_BYPASS=0) produces a used decode source.
REQ-013 m_pc_src=1 SHALL assert flush_d=flush_e=flush_m and force stall_f=stall_d=0 in the same cycle (flush overrides stall).
REQ-014 All hazard outputs SHALL be combinational from scoreboard and current inputs; latency zero cycles.
REQ-015 stall_cnt SHALL increment on every clock where stall_d=1; flush_cnt on every clock where m_pc_src=1; both SHALL saturate at all-ones, never wrap.
REQ-016 flush_m SHALL assert only on m_pc_src.

Reset
REQ-017 reset low SHALL immediately clear all scoreboard valids and both counters, regardless of clk.
REQ-018 While reset is low, every output SHALL be 0.
REQ-019 Release SHALL take effect at the first rising clk edge with reset high; a mid-stream reset discards all tracked hazards.

Structure
REQ-020 Shared package SHALL hold the forwarding-select constants (FWD_RF=00, FWD_W=01, FWD_M=10) and the scoreboard-entry record type, for reuse by the datapath operand muxes.
REQ-021 One sub-module, hazard_cmp, SHALL compare one source address against one scoreboard entry (match = valid & regwrite & dst!=0 & addr==dst & uses); it is instantiated per source/entry pair.

Verification
REQ-022 add r3,.. then sub ..,r3,.. back-to-back -> fwd_a_e=10 in sub's execute cycle, no stall.
REQ-023 add r3 followed two instructions later by a reader of r3 as rt -> fwd_b_e=01.
REQ-024 lw r2 then add r4,r2,r5 -> stall_f=stall_d=flush_e=1 for exactly one cycle, then fwd_a_e=01; stall_cnt=1.
REQ-025 m_pc_src=1 coinciding with a load-use hazard -> flush_d=flush_e=flush_m=1, stall_f=stall_d=0; flush_cnt increments by 1.
REQ-026 Writer to r0 followed by reader of r0 -> fwd 00, no stall; FWD_EN=0, REG_BYPASS=1, back-to-back dependent pair -> stall 2 cycles (3 with REG_BYPASS=0).
REQ-027 reset pulled low mid-sequence between clk edges -> outputs 0 immediately; counters read 0 after release; CNT_W=2 with 5 stalls -> stall_cnt=3.
